// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the N-way arbitrated output mux.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: arbitration FSM state type, select-width helper, reset values.
package mux_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam arb_state_t STATE_RST     = ARB;
  localparam logic       OUT_VALID_RST = 1'b0;
  localparam logic       OUT_LAST_RST  = 1'b0;

  // Index width that stays legal for degenerate N (a 1-input mux still
  // needs a 1-bit select so port declarations never collapse to [-1:0]).
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational N-request arbiter: round-robin from ptr, or fixed lowest-index.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller gates the grant with its own load enable.
//
// Ports:
//   prio_mode  0 = round-robin starting at ptr, 1 = lowest requesting index wins
//   ptr        round-robin start index (ignored in fixed mode)
//   req        per-channel request vector
//   grant      one-hot grant, all zero when no request
//   idx        encoded index of the granted channel (0 when no grant)
module rr_arbiter_n #(
  parameter int N     = 8,
  parameter int SEL_W = 3
) (
  input  logic             prio_mode,
  input  logic [SEL_W-1:0] ptr,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] idx
);

  logic             found;
  int               cand;
  logic [SEL_W-1:0] cidx;

  // Scan N candidates in priority order; the first requester wins. The
  // modulo keeps the wrap correct when N is not a power of two.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    cidx  = '0;
    for (int k = 0; k < N; k++) begin
      cand = prio_mode ? k : ((int'(ptr) + k) % N);
      cidx = SEL_W'(cand);
      if (!found && req[cidx]) begin
        found       = 1'b1;
        grant[cidx] = 1'b1;
        idx         = cidx;
      end
    end
  end

endmodule

// File: rtl/mux_arb_nxw.sv
// N-input W-bit arbitrated mux with packet locking and one registered output stage.
// Latency: 1 cycle from input transfer to out_valid; one beat per cycle sustained.
// Backpressure: all in_ready drop while the out register is full and out_ready is low.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_data/valid/last      per-channel beat, handshake and end-of-packet flag
//   in_ready                per-channel ready, at most one bit high
//   prio_mode               0 = round-robin, 1 = fixed priority (lowest index)
//   out_data/last/sel/valid registered output beat and source channel
//   out_ready               downstream ready
//   pkt_count               wrapping count of last beats loaded into the out register
module mux_arb_nxw
  import mux_arb_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int W     = 32,
  parameter  int CNT_W = 16,
  localparam int SEL_W = sel_w(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0][W-1:0] in_data,
  input  logic [N-1:0]        in_valid,
  input  logic [N-1:0]        in_last,
  output logic [N-1:0]        in_ready,
  input  logic                prio_mode,
  output logic [W-1:0]        out_data,
  output logic                out_last,
  output logic [SEL_W-1:0]    out_sel,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CNT_W-1:0]    pkt_count
);

  arb_state_t       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] lock_q, lock_d;

  logic [N-1:0]     arb_grant;
  logic [SEL_W-1:0] arb_idx;
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] sel_idx;
  logic [SEL_W-1:0] next_idx;
  logic             load;
  logic             xfer;
  logic             xfer_last;

  rr_arbiter_n #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arb (
    .prio_mode (prio_mode),
    .ptr       (ptr_q),
    .req       (in_valid),
    .grant     (arb_grant),
    .idx       (arb_idx)
  );

  // While a packet is in flight only the owning channel may be granted, and
  // only when it actually presents a beat; otherwise the cycle is a bubble.
  always_comb begin
    grant   = '0;
    sel_idx = arb_idx;
    if (state_q == LOCKED) begin
      grant[lock_q] = in_valid[lock_q];
      sel_idx       = lock_q;
    end else begin
      grant = arb_grant;
    end
  end

  assign load      = !out_valid || out_ready;
  // rst_n gating keeps in_ready low for the whole reset window even though
  // the empty out register would otherwise make load true.
  assign in_ready  = (load && rst_n) ? grant : '0;
  assign xfer      = |(in_valid & in_ready);
  assign xfer_last = in_last[sel_idx];
  assign next_idx  = (sel_idx == SEL_W'(N - 1)) ? '0 : sel_idx + SEL_W'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    if (xfer) begin
      if (xfer_last) begin
        state_d = ARB;
        ptr_d   = next_idx;
      end else begin
        state_d = LOCKED;
        lock_d  = sel_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STATE_RST;
      ptr_q   <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
    end
  end

  // Out register: payload only changes on a transfer; an empty load slot
  // just clears valid so stale data is never re-presented as a new beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= OUT_VALID_RST;
      out_data  <= '0;
      out_last  <= OUT_LAST_RST;
      out_sel   <= '0;
    end else if (load) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= in_data[sel_idx];
        out_last <= xfer_last;
        out_sel  <= sel_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count <= '0;
    end else if (xfer && xfer_last) begin
      pkt_count <= pkt_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mux_arb_nxw.sv
module tb_mux_arb_nxw;

  localparam int N     = 8;
  localparam int W     = 32;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  logic                clk   = 1'b0;
  logic                rst_n = 1'b1;
  logic [N-1:0][W-1:0] in_data;
  logic [N-1:0]        in_valid;
  logic [N-1:0]        in_last;
  logic [N-1:0]        in_ready;
  logic                prio_mode;
  logic [W-1:0]        out_data;
  logic                out_last;
  logic [2:0]          out_sel;
  logic                out_valid;
  logic                out_ready;
  logic [CNT_W-1:0]    pkt_count;

  beat_t      chq[N][$];    // beats still to be offered per channel
  beat_t      chexp[N][$];  // beats still expected at the output per channel
  int         exp_q[$];     // expected order of source channels at the output
  logic [N-1:0] hold;       // forces a channel's valid low (bubble)
  logic [N-1:0] blk_mask;   // channels that must see in_ready=0 this phase
  int         total   = 0;
  int         bad     = 0;
  int         seq     = 0;
  int         exp_pkt = 0;
  logic [W-1:0] d0;

  always #5 clk = ~clk;

  mux_arb_nxw #(
    .N     (N),
    .W     (W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .prio_mode (prio_mode),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pkt_count (pkt_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic add_pkt(input int ch, input int nb);
    beat_t b;
    for (int k = 0; k < nb; k++) begin
      b.data = {8'(ch), 8'hC0, 16'(seq)};
      b.last = (k == nb - 1);
      chq[ch].push_back(b);
      chexp[ch].push_back(b);
      seq++;
    end
  endtask

  task automatic exp_ord(input int ch, input int nb);
    for (int k = 0; k < nb; k++) exp_q.push_back(ch);
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (chq[i].size() > 0 && !hold[i[2:0]]) begin
        in_valid[i[2:0]] = 1'b1;
        in_data[i[2:0]]  = chq[i][0].data;
        in_last[i[2:0]]  = chq[i][0].last;
      end else begin
        in_valid[i[2:0]] = 1'b0;
        in_last[i[2:0]]  = 1'b0;
      end
    end
  endtask

  task automatic check_out();
    int    es;
    beat_t eb;
    if (exp_q.size() == 0) begin
      chk("unexpected_beat", 32'(out_valid), 32'd0);
    end else begin
      es = exp_q.pop_front();
      chk("out_sel", 32'(out_sel), 32'(es));
      if (chexp[es].size() > 0) begin
        eb = chexp[es].pop_front();
        chk("out_data", out_data, eb.data);
        chk("out_last", 32'(out_last), 32'(eb.last));
      end else begin
        chk("chan_underflow", 32'(chexp[es].size()), 32'd1);
      end
    end
  endtask

  // One clock: present inputs at the falling edge, sample just after, let the
  // rising edge commit, and come back to the next falling edge.
  task automatic cycle();
    logic [N-1:0] fire;
    drive_inputs();
    #1;
    fire = in_valid & in_ready;
    chk("ready_onehot0", 32'($onehot0(in_ready)), 32'd1);
    if (blk_mask != '0) chk("blocked_ready", 32'(in_ready & blk_mask), 32'd0);
    if (out_valid && out_ready) check_out();
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (fire[i[2:0]]) void'(chq[i].pop_front());
    end
    @(negedge clk);
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < maxc) begin
      cycle();
      n++;
    end
    chk("drain_budget", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    in_data   = '0;
    in_valid  = '0;
    in_last   = '0;
    prio_mode = 1'b0;
    out_ready = 1'b1;
    hold      = '0;
    blk_mask  = '0;

    // Async reset mid-cycle with no clock edge yet.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("rst_out_sel", 32'(out_sel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after release.
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("idle_out_valid", 32'(out_valid), 32'd0);
    end

    // Round-robin: all channels busy with single-beat packets.
    prio_mode = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < N; c++) add_pkt(c, 1);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < N; c++) exp_ord(c, 1);
    for (int k = 0; k < 8; k++) cycle();
    chk("rr_pkt_after8", 32'(pkt_count), 32'd8);
    drain(40);
    exp_pkt = (exp_pkt + 16) % 16;
    chk("rr_pkt_wrap", 32'(pkt_count), 32'(exp_pkt));

    // Fixed priority: 2 beats 5 while both valid.
    prio_mode = 1'b1;
    for (int k = 0; k < 4; k++) add_pkt(2, 1);
    for (int k = 0; k < 4; k++) add_pkt(5, 1);
    exp_ord(2, 4);
    exp_ord(5, 4);
    blk_mask = 8'h20;
    for (int k = 0; k < 4; k++) cycle();
    blk_mask = '0;
    drain(40);
    exp_pkt = (exp_pkt + 8) % 16;
    chk("fix_pkt", 32'(pkt_count), 32'(exp_pkt));

    // Packet lock on ch3 with a 2-cycle bubble while ch1 waits.
    prio_mode = 1'b0;
    add_pkt(3, 4);
    exp_ord(3, 4);
    exp_ord(1, 1);
    cycle();
    add_pkt(1, 1);
    blk_mask = 8'h02;
    cycle();
    hold[3] = 1'b1;
    cycle();
    cycle();
    hold[3] = 1'b0;
    cycle();
    chk("lock_pkt_mid", 32'(pkt_count), 32'(exp_pkt));
    cycle();
    blk_mask = '0;
    chk("lock_pkt_end", 32'(pkt_count), 32'((exp_pkt + 1) % 16));
    drain(40);
    exp_pkt = (exp_pkt + 2) % 16;
    chk("lock_pkt_final", 32'(pkt_count), 32'(exp_pkt));

    // Backpressure: hold the out register for 3 cycles.
    add_pkt(4, 1);
    add_pkt(4, 1);
    add_pkt(6, 1);
    exp_ord(4, 1);
    exp_ord(6, 1);
    exp_ord(4, 1);
    d0 = chexp[4][0].data;
    cycle();
    out_ready = 1'b0;
    blk_mask  = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_sel", 32'(out_sel), 32'd4);
      chk("bp_out_data", out_data, d0);
    end
    blk_mask  = '0;
    out_ready = 1'b1;
    cycle();
    chk("bp_reload_valid", 32'(out_valid), 32'd1);
    chk("bp_reload_sel", 32'(out_sel), 32'd6);
    drain(40);
    exp_pkt = (exp_pkt + 3) % 16;
    chk("bp_pkt", 32'(pkt_count), 32'(exp_pkt));

    // Counter wrap: 4 more packets brings the total to 33 -> 1 in 4 bits.
    for (int k = 0; k < 4; k++) add_pkt(0, 1);
    exp_ord(0, 4);
    drain(40);
    exp_pkt = (exp_pkt + 4) % 16;
    chk("wrap_pkt", 32'(pkt_count), 32'(exp_pkt));
    chk("wrap_pkt_one", 32'(pkt_count), 32'd1);

    // Reset during a locked packet on ch5 while ch5 still presents a beat.
    add_pkt(5, 3);
    cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_pkt", 32'(pkt_count), 32'd0);
    chq[5].delete();
    chexp[5].delete();
    exp_q.delete();
    drive_inputs();
    @(negedge clk);
    rst_n   = 1'b1;
    exp_pkt = 0;
    add_pkt(6, 1);
    add_pkt(2, 1);
    exp_ord(2, 1);
    exp_ord(6, 1);
    cycle();
    chk("post_rst_sel", 32'(out_sel), 32'd2);
    drain(40);
    exp_pkt = 2;
    chk("post_rst_pkt", 32'(pkt_count), 32'(exp_pkt));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_arb_nxw.md
Name: mux_arb_nxw

Overview:
- Parametrised N-input, W-bit arbitrated multiplexer with per-channel valid/ready handshakes and one registered output stage.
- Replaces the static select-driven mux for datapaths where several producers share one consumer.
- Supports round-robin or fixed-priority arbitration.
- Locks the grant for multi-beat packets delimited by a last flag.
- Keeps a wrapping count of completed packets.

Parameters:
- N, 8, number of input channels (N >= 2).
- W, 32, data width per channel.
- CNT_W, 16, width of the completed-packet counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  [N-1:0][W-1:0]  per-channel data.
- in_valid  input  N  per-channel valid.
- in_last  input  N  per-channel end-of-packet flag, qualified by in_valid.
- in_ready  output  N  per-channel ready; at most one bit high.
- prio_mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- out_data  output  W  registered data.
- out_last  output  1  registered last flag.
- out_sel  output  $clog2(N)  index of the channel that produced the current out beat.
- out_valid  output  1  registered valid.
- out_ready  input  1  downstream ready.
- pkt_count  output  CNT_W  number of packets completed (last beat accepted into out register), wraps.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, out_last=0, out_sel=0, pkt_count=0.
  - RR pointer=0, state=ARB.
  - in_ready=0 while rst_n=0.
- Load enable: load = !out_valid || out_ready. in_ready[i] = load && grant[i].
- Transfer on channel i occurs when in_valid[i] && in_ready[i]. On a transfer the out register captures in_data[i], in_last[i], i, and sets out_valid=1 at the next edge.
- If load && no transfer: out_valid <= 0. If !load, all out registers hold.
- Latency: 1 cycle input-to-out_valid. Full throughput: one beat/cycle with out_ready held 1.
- grant is one-hot or zero and only selects channels with in_valid=1. It is combinational from the current state, pointer, prio_mode and in_valid.
- State ARB:
  - Round-robin: search starts at the pointer, ascending, wrapping N-1 -> 0; first valid wins.
  - Fixed: lowest valid index wins.
  - Transfer with in_last=1: stay ARB; pkt_count+1; pointer <= (granted+1) mod N in both modes.
  - Transfer with in_last=0: go LOCKED, lock_idx <= granted.
- State LOCKED:
  - grant = lock_idx only, when in_valid[lock_idx]=1. Other channels see in_ready=0 even if valid.
  - prio_mode is ignored.
  - Transfer with in_last=1 -> ARB; pkt_count+1; pointer <= (lock_idx+1) mod N.
  - in_valid[lock_idx]=0 creates a bubble; the block stays LOCKED indefinitely, with no timeout.
- prio_mode is sampled every cycle in ARB only. A change takes effect on the next arbitration decision.
- Simultaneous events:
  - A new beat may load in the same cycle the held beat is consumed (out_valid && out_ready).
  - The pointer and state update in the same edge as the transfer.
- pkt_count wraps 2^CNT_W-1 -> 0 with no saturation or flag.
- Reset mid-packet returns to ARB with the pointer at 0. A partially forwarded packet is abandoned; there is no recovery.
- Upstream contract: in_data and in_last hold stable while in_valid=1 and not accepted. The block does not check this.

Decomposition:
- Package mux_arb_pkg: typedef enum logic {ARB, LOCKED} arb_state_t; function clog2-safe SEL_W helper; localparam reset values.
- Sub-module rr_arbiter_n (N, prio_mode, ptr, req -> one-hot grant and encoded index), purely combinational and reused elsewhere.
- Top holds state, pointer, lock_idx, out register, counter.

Test Plan:
- Reset then idle: rst_n=0 mid-cycle -> out_valid=0, in_ready=0, pkt_count=0 immediately (async). After release with no in_valid -> out_valid stays 0.
- RR fairness: prio_mode=0, all 8 channels valid, single-beat (in_last=1), out_ready=1 -> out_sel sequence 0,1,...,7,0 on consecutive cycles; pkt_count=8 after 8 beats.
- Fixed priority: prio_mode=1, channels 2 and 5 valid continuously, single-beat -> out_sel=2 every cycle; in_ready[5]=0 throughout.
- Packet lock: channel 3 sends 4 beats (last on 4th) while channel 1 valid -> out_sel=3 for 4 beats, then 1. A bubble on ch3 (valid low 2 cycles) keeps ch1 blocked. pkt_count+1 only at beat 4.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_sel stable, all in_ready=0. out_ready=1 -> next beat loads same cycle, no beat lost or duplicated (scoreboard by channel/sequence).
- Counter wrap: CNT_W=4, 17 single-beat packets -> pkt_count=1. Reset asserted during a locked packet -> state ARB, pointer 0; next arbitration picks lowest valid channel.
